// File: rtl/nios_key_pkg.sv
// Shared register map and reset-level helper for the key/switch input port.
// Register addresses are Avalon word addresses.
package nios_key_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Idle level of an input: keys rest high when falling edges are captured.
   function automatic logic idle_level(input int capture_rising);
      return (capture_rising != 0) ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/nios_key_debounce.sv
// One input bit: 2-flop synchronizer followed by a stability-window debouncer.
// The stable output flips DEBOUNCE_CYCLES+2 edges after a clean change is first sampled.
module nios_key_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RST_VAL         = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = din;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= RST_VAL;
         sync2_q  <= RST_VAL;
         stable_q <= RST_VAL;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // Edge pulses are asserted in the cycle whose closing edge updates stable.
   assign stable = stable_q;
   assign rise   = ~stable_q & stable_d;
   assign fall   = stable_q & ~stable_d;

endmodule

// File: rtl/nios_key_in.sv
// Avalon-MM PIO-style input port: debounced data, irq mask and sticky edge capture.
// Reads are combinational; edgecapture set takes priority over a same-cycle clear.
module nios_key_in
   import nios_key_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CAPTURE_RISING  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic IDLE = idle_level(CAPTURE_RISING);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] cap_set;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RST_VAL         (IDLE)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (in_port[i]),
         .stable  (stable[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   assign cap_set      = (CAPTURE_RISING != 0) ? rise : fall;
   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      irqmask_d = irqmask_q;
      cap_clr   = '0;
      if (wr_en && (address == ADDR_IRQMASK)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end
      if (wr_en && (address == ADDR_EDGECAP)) begin
         cap_clr = writedata[WIDTH-1:0];
      end
      edgecap_d = (edgecap_q & ~cap_clr) | cap_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_q <= '0;
         edgecap_q <= '0;
      end else begin
         irqmask_q <= irqmask_d;
         edgecap_q <= edgecap_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = stable;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
         default:      readdata            = '0;
      endcase
   end

   assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_key_in.sv
// Self-checking bench for nios_key_in with WIDTH=4, DEBOUNCE_CYCLES=8, falling-edge capture.
// Expected read values are queued when stimulus is applied and popped when readdata is sampled.
module tb_nios_key_in;

   localparam int W  = 4;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   readdata;
   logic          irq;

   int            checks = 0;
   int            fails  = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   exp_v;

   nios_key_in #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DB),
      .CAPTURE_RISING  (0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Single-cycle Avalon write; entered just after a rising edge, returns just after the next.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic test_reset();
      logic [1:0] addrs [3];
      addrs      = '{2'd0, 2'd2, 2'd3};
      reset_n    = 1'b0;
      in_port    = '1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      #2;
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_irq_during: irq=%b expected 0", irq);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      for (int i = 0; i < 3; i++) begin
         address = addrs[i];
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (readdata !== exp_v) begin
            fails++;
            $display("FAIL reset_read addr%0d: readdata=0x%0h expected 0x%0h", addrs[i], readdata, exp_v);
         end
      end
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_irq: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_reserved();
      @(posedge clk);
      #1;
      bus_write(2'd1, 32'hFFFF_FFFF);
      exp_q.push_back(32'h0);
      address = 2'd1;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL reserved_read: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
   endtask

   task automatic test_hold();
      @(posedge clk);
      #1;
      address = 2'd0;
      in_port = 4'hE;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'hE);
      exp_q.push_back(32'h1);
      repeat (DB + 1) @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL hold_early: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL hold_data: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      address = 2'd3;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL hold_edgecap: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL hold_irq_masked: irq=%b expected 0", irq);
      end
      in_port = 4'hF;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'h1);
      repeat (DB + 4) @(posedge clk);
      @(negedge clk);
      address = 2'd0;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL release_data: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      address = 2'd3;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL release_edgecap_sticky: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
   endtask

   task automatic test_irq();
      @(posedge clk);
      #1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = 2'd2;
      writedata  = 32'hFFFF_FFF1;
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL irq_before_mask: irq=%b expected 0", irq);
      end
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      checks++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL irq_after_mask: irq=%b expected 1", irq);
      end
      exp_q.push_back(32'h1);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL irqmask_read: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      exp_q.push_back(32'h0);
      bus_write(2'd3, 32'h1);
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL edgecap_clear: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL irq_after_clear: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_glitch();
      @(posedge clk);
      #1;
      in_port = 4'hD;
      repeat (5) @(posedge clk);
      #1;
      in_port = 4'hF;
      for (int c = 0; c < 3 * DB; c++) begin
         exp_q.push_back(32'hF);
         address = 2'd0;
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (readdata !== exp_v) begin
            fails++;
            $display("FAIL glitch_data cycle%0d: readdata=0x%0h expected 0x%0h", c, readdata, exp_v);
         end
      end
      exp_q.push_back(32'h0);
      address = 2'd3;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL glitch_edgecap: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
   endtask

   task automatic test_collide();
      @(posedge clk);
      #1;
      in_port = 4'hB;
      exp_q.push_back(32'h4);
      exp_q.push_back(32'hB);
      repeat (DB + 1) @(posedge clk);
      #1;
      bus_write(2'd3, 32'h4);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL collide_set_wins: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL collide_irq_masked: irq=%b expected 0", irq);
      end
      address = 2'd0;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL collide_data: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      @(posedge clk);
      #1;
      exp_q.push_back(32'h0);
      bus_write(2'd3, 32'h4);
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL collide_later_clear: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      in_port = 4'hF;
      repeat (DB + 4) @(posedge clk);
   endtask

   task automatic test_reset_abort();
      @(posedge clk);
      #1;
      in_port = 4'hE;
      repeat (7) @(posedge clk);
      #1;
      reset_n = 1'b0;
      in_port = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.push_back(32'hF);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      repeat (2 * DB) @(posedge clk);
      @(negedge clk);
      address = 2'd0;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL abort_data: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      address = 2'd3;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL abort_edgecap: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      address = 2'd2;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (readdata !== exp_v) begin
         fails++;
         $display("FAIL abort_irqmask: readdata=0x%0h expected 0x%0h", readdata, exp_v);
      end
      checks++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL abort_irq: irq=%b expected 0", irq);
      end
   endtask

   initial begin
      test_reset();
      test_reserved();
      test_hold();
      test_irq();
      test_glitch();
      test_collide();
      test_reset_abort();
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
